fire_dispatcher: RTL and testbench

//  Consumer end of the fire FIFO. Once per timestep it drains every queued fire tag.
//  For each popped source tag it issues one synaptic-update request per target neuron
//  to the neuron-update stage, using a valid/ready handshake. All-to-all connectivity.

---
 rtl/fire_dispatcher.sv | 82 ++++++++
 tb/tb_fire_dispatcher.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fire_dispatcher.sv
// fire_dispatcher: drains the fire FIFO once per timestep and issues all-to-all synaptic updates
//  clk          rising-edge clock
//  asyn_reset_n asynchronous reset, active low
//  step_start   pulse that begins draining for this timestep (honoured in IDLE only)
//  fifo_empty   FIFO empty flag, sampled only in DRAIN
//  fifo_tag     head-of-FIFO source tag
//  fifo_deq     pop request, high only in DRAIN with a non-empty FIFO
//  upd_valid    update request valid (valid/ready handshake with upd_ready)
//  upd_ready    downstream accepts the update on an edge with valid & ready
//  upd_src      source neuron of the update
//  upd_tgt      target neuron of the update
//  upd_last     last update issued for the current source
//  busy         high in every state except IDLE
//  step_done    one-cycle pulse when the timestep dispatch is complete
//  spike_count  tags popped since the last step_start, saturating
module fire_dispatcher #(
  parameter int NUMNEURONS = 2,
  parameter int TAGBITS = 1,
  parameter bit SKIP_SELF = 1
) (
  input  logic               clk,
  input  logic               asyn_reset_n,
  input  logic               step_start,
  input  logic               fifo_empty,
  input  logic [TAGBITS-1:0] fifo_tag,
  output logic               fifo_deq,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [TAGBITS-1:0] upd_src,
  output logic [TAGBITS-1:0] upd_tgt,
  output logic               upd_last,
  output logic               busy,
  output logic               step_done,
  output logic [TAGBITS:0]   spike_count
);
  typedef enum logic [1:0] {IDLE, DRAIN, SEND, DONE} state_t;
  localparam logic [TAGBITS-1:0] LAST = TAGBITS'(NUMNEURONS - 1);
  localparam logic [TAGBITS-1:0] PRE = TAGBITS'(NUMNEURONS - 2);
  // The "second to last" rule only makes sense when a second-to-last target exists.
  localparam bit PRE_OK = SKIP_SELF && (NUMNEURONS >= 2);
  state_t state;
  logic [TAGBITS-1:0] src, tgt;
  logic skip;
  assign skip = SKIP_SELF && (tgt == src);
  assign fifo_deq = (state == DRAIN) && !fifo_empty;
  assign upd_valid = (state == SEND) && !skip;
  assign upd_src = src;
  assign upd_tgt = tgt;
  // When the source is the final neuron and self-updates are skipped, the
  // second-to-last target is the final one actually issued.
  assign upd_last = (state == SEND) && ((tgt == LAST) || (PRE_OK && src == LAST && tgt == PRE));
  assign busy = state != IDLE;
  assign step_done = state == DONE;
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state <= IDLE;
      src <= '0;
      tgt <= '0;
      spike_count <= '0;
    end else begin
      case (state)
        IDLE: if (step_start) begin
          state <= DRAIN;
          spike_count <= '0;
        end
        DRAIN: if (fifo_empty) state <= DONE;
        else begin
          src <= fifo_tag;
          tgt <= '0;
          spike_count <= &spike_count ? spike_count : spike_count + 1'b1;
          state <= SEND;
        end
        // Skipped targets advance without a handshake; otherwise hold until accepted.
        SEND: if (skip || upd_ready) begin
          if (tgt == LAST) state <= DRAIN;
          else tgt <= tgt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fire_dispatcher.sv
// tb_fire_dispatcher: directed vectors for fire_dispatcher with and without self-skip
module tb_fire_dispatcher;
  typedef struct {
    int k;
    int ntags;
    logic [1:0] t0, t1;
    int nupd;
    logic [7:0][4:0] exp;
    int cnt;
  } vec_t;
  logic clk = 0, rst_n = 1, ready = 1;
  logic st [2] = '{0, 0};
  logic empty [2], deq [2], valid [2], last [2], busy [2], done [2];
  logic [1:0] tag [2], src [2], tgt [2];
  logic [2:0] cnt [2];
  logic [1:0] mem [2][16];
  logic [3:0] head [2] = '{0, 0};
  logic [3:0] tail [2] = '{0, 0};
  logic [4:0] logm [2][64];
  int nlog [2] = '{0, 0};
  int ndeq [2] = '{0, 0};
  int ndone [2] = '{0, 0};
  int total = 0, bad = 0;
  vec_t vecs [6];
  always #5 clk = ~clk;
  assign empty[0] = head[0] == tail[0];
  assign empty[1] = head[1] == tail[1];
  assign tag[0] = mem[0][head[0]];
  assign tag[1] = mem[1][head[1]];
  fire_dispatcher #(.NUMNEURONS(4), .TAGBITS(2), .SKIP_SELF(1)) dut_a (
    .clk(clk), .asyn_reset_n(rst_n), .step_start(st[0]), .fifo_empty(empty[0]),
    .fifo_tag(tag[0]), .fifo_deq(deq[0]), .upd_valid(valid[0]), .upd_ready(ready),
    .upd_src(src[0]), .upd_tgt(tgt[0]), .upd_last(last[0]), .busy(busy[0]),
    .step_done(done[0]), .spike_count(cnt[0]));
  fire_dispatcher #(.NUMNEURONS(4), .TAGBITS(2), .SKIP_SELF(0)) dut_b (
    .clk(clk), .asyn_reset_n(rst_n), .step_start(st[1]), .fifo_empty(empty[1]),
    .fifo_tag(tag[1]), .fifo_deq(deq[1]), .upd_valid(valid[1]), .upd_ready(ready),
    .upd_src(src[1]), .upd_tgt(tgt[1]), .upd_last(last[1]), .busy(busy[1]),
    .step_done(done[1]), .spike_count(cnt[1]));
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (deq[i]) begin
        head[i] <= head[i] + 4'd1;
        ndeq[i] <= ndeq[i] + 1;
      end
      if (valid[i] && ready) begin
        logm[i][nlog[i][5:0]] <= {last[i], src[i], tgt[i]};
        nlog[i] <= nlog[i] + 1;
      end
      if (done[i]) ndone[i] <= ndone[i] + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string name);
    chk({name, " a"}, {deq[0], valid[0], src[0], tgt[0], last[0], busy[0], done[0], cnt[0]}, 0);
    chk({name, " b"}, {deq[1], valid[1], src[1], tgt[1], last[1], busy[1], done[1], cnt[1]}, 0);
  endtask
  task automatic start(input int k, input int n, input logic [1:0] t0, input logic [1:0] t1);
    if (n > 0) begin
      mem[k][tail[k]] = t0;
      tail[k] = tail[k] + 4'd1;
    end
    if (n > 1) begin
      mem[k][tail[k]] = t1;
      tail[k] = tail[k] + 4'd1;
    end
    st[k] = 1;
    @(negedge clk);
    st[k] = 0;
  endtask
  task automatic run_vec(input string name, input vec_t v);
    int b, d, nd, c;
    b = nlog[v.k];
    d = ndeq[v.k];
    nd = ndone[v.k];
    start(v.k, v.ntags, v.t0, v.t1);
    c = 0;
    while (ndone[v.k] == nd && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk({name, " done seen"}, 32'(c < 300), 1);
    chk({name, " done pulses"}, ndone[v.k] - nd, 1);
    chk({name, " updates"}, nlog[v.k] - b, v.nupd);
    for (int i = 0; i < v.nupd; i++)
      chk($sformatf("%s upd%0d {last,src,tgt}", name, i), logm[v.k][b + i], v.exp[i]);
    chk({name, " deq pulses"}, ndeq[v.k] - d, v.ntags);
    chk({name, " spike_count"}, cnt[v.k], v.cnt);
    chk({name, " busy"}, busy[v.k], 0);
  endtask
  initial begin
    int c;
    vecs[0] = '{0, 1, 2'd2, 2'd0, 3, {25'b0, 5'b1_10_11, 5'b0_10_01, 5'b0_10_00}, 1};
    vecs[1] = '{0, 0, 2'd0, 2'd0, 0, 40'b0, 0};
    vecs[2] = '{1, 2, 2'd1, 2'd3, 8, {5'b1_11_11, 5'b0_11_10, 5'b0_11_01, 5'b0_11_00,
                                      5'b1_01_11, 5'b0_01_10, 5'b0_01_01, 5'b0_01_00}, 2};
    vecs[3] = '{0, 1, 2'd3, 2'd0, 3, {25'b0, 5'b1_11_10, 5'b0_11_01, 5'b0_11_00}, 1};
    vecs[4] = '{0, 2, 2'd0, 2'd0, 6, {10'b0, 5'b1_00_11, 5'b0_00_10, 5'b0_00_01,
                                      5'b1_00_11, 5'b0_00_10, 5'b0_00_01}, 2};
    vecs[5] = '{1, 1, 2'd2, 2'd0, 4, {20'b0, 5'b1_10_11, 5'b0_10_10, 5'b0_10_01, 5'b0_10_00}, 1};
    #3 rst_n = 0;
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("busy after reset", busy[0], 0);
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    st[0] = 1;
    @(posedge clk);
    #1 st[0] = 0;
    chk("empty c1 busy/done/deq/valid", {busy[0], done[0], deq[0], valid[0]}, 4'b1000);
    @(posedge clk);
    #1 chk("empty c2 done", done[0], 1);
    chk("empty c2 deq/valid", {deq[0], valid[0]}, 0);
    @(posedge clk);
    #1 chk("empty c3 done/busy", {done[0], busy[0]}, 0);
    chk("empty spike_count", cnt[0], 0);
    @(negedge clk);
    ready = 0;
    begin
      int b;
      b = nlog[0];
      start(0, 1, 2'd1, 2'd0);
      c = 0;
      while (!valid[0] && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("stall valid seen", 32'(c < 20), 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("stall hold%0d valid/src/tgt/last", i), {valid[0], src[0], tgt[0], last[0]}, 6'b1_01_00_0);
        if (i == 3) ready = 1;
        @(negedge clk);
      end
      c = 0;
      while (busy[0] && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk("stall updates", nlog[0] - b, 3);
      chk("stall upd0", logm[0][b], 5'b0_01_00);
      chk("stall upd1", logm[0][b + 1], 5'b0_01_10);
      chk("stall upd2", logm[0][b + 2], 5'b1_01_11);
    end
    start(0, 1, 2'd2, 2'd0);
    c = 0;
    while (!(valid[0] && tgt[0] == 2'd1) && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("abort reached (2,1)", {valid[0], src[0], tgt[0]}, 5'b1_10_01);
    #2 rst_n = 0;
    #1 chk_zero("mid-send reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("busy after abort", busy[0], 0);
    run_vec("after abort", '{0, 1, 2'd0, 2'd0, 3, {25'b0, 5'b1_00_11, 5'b0_00_10, 5'b0_00_01}, 1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
